riscv_trace_capture: RTL and testbench

//  Consumes the riscv core's commit/debug ports (register-write and data-memory strobes) every cycle.

---
 rtl/trace_pkg.sv | 19 +
 rtl/trace_fifo_2w1r.sv | 56 +++++
 rtl/riscv_trace_capture.sv | 112 +++++++++++
 tb/tb_riscv_trace_capture.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the commit/debug trace capture path.
package trace_pkg;

  typedef enum logic [1:0] {
    KIND_REG  = 2'b00,
    KIND_MEMW = 2'b01,
    KIND_MEMR = 2'b10
  } kind_e;

  localparam int unsigned TRACE_TS_W = 16;

  typedef struct packed {
    kind_e                 kind;
    logic [8:0]            idx;
    logic [31:0]           data;
    logic [TRACE_TS_W-1:0] ts;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Two-push / one-pop FIFO with a registered head entry.
module trace_fifo_2w1r #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 59,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push0,
  input  logic          push1,
  input  logic [W-1:0]  din0,
  input  logic [W-1:0]  din1,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp, wp1, rp_next;
  logic [LW-1:0] level_next;

  always_comb begin
    wp1        = wp + AW'(1);
    rp_next    = rp + AW'(pop);
    level_next = level + LW'(push0) + LW'(push1) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push0) mem[wp]  <= din0;
    if (push1) mem[wp1] <= din1;
  end

  // Head is reloaded from the slot rp_next points at, bypassing same-edge writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      head  <= '0;
    end else begin
      wp    <= wp + AW'(push0) + AW'(push1);
      rp    <= rp_next;
      level <= level_next;
      if (level_next != '0) begin
        if (push0 && wp == rp_next)
          head <= din0;
        else if (push1 && wp1 == rp_next)
          head <= din1;
        else
          head <= mem[rp_next];
      end
    end
  end

endmodule

// File: rtl/riscv_trace_capture.sv
// Captures core register-write and data-memory strobes into timestamped trace records.
module riscv_trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   reg_write_sig,
  input  logic [4:0]             reg_num,
  input  logic [31:0]            reg_data,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [8:0]             addr,
  input  logic [31:0]            wr_data,
  input  logic [31:0]            rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output kind_e                  out_kind,
  output logic [8:0]             out_idx,
  output logic [31:0]            out_data,
  output logic [TS_W-1:0]        out_ts,
  output logic [$clog2(DEPTH):0] level,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   overflow
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    kind_e           kind;
    logic [8:0]      idx;
    logic [31:0]     data;
    logic [TS_W-1:0] ts;
  } rec_t;

  localparam int unsigned RW = $bits(rec_t);

  logic [TS_W-1:0] ts;
  rec_t            mem_rec, reg_rec, rec0, rec1, head;
  logic            mem_ev, reg_ev, pop, push0, push1;
  logic [1:0]      need, pushes, drops;
  logic [LW:0]     free;
  logic [DROP_W:0] drop_sum;

  always_comb begin
    mem_ev = en && (wr ^ rd);
    reg_ev = en && reg_write_sig && (reg_num != '0);

    mem_rec.kind = wr ? KIND_MEMW : KIND_MEMR;
    mem_rec.idx  = addr;
    mem_rec.data = wr ? wr_data : rd_data;
    mem_rec.ts   = ts;

    reg_rec.kind = KIND_REG;
    reg_rec.idx  = {4'b0000, reg_num};
    reg_rec.data = reg_data;
    reg_rec.ts   = ts;

    // Pushes are compacted onto port 0 first; MEM always precedes REG.
    rec0 = mem_ev ? mem_rec : reg_rec;
    rec1 = reg_rec;

    out_valid = (level != '0);
    pop       = out_valid && out_ready;
    free      = (LW+1)'(DEPTH) - {1'b0, level} + (LW+1)'(pop);
    need      = {1'b0, mem_ev} + {1'b0, reg_ev};
    push0     = (need != 2'd0) && (free != '0);
    push1     = (need == 2'd2) && (free >= (LW+1)'(2));
    pushes    = {1'b0, push0} + {1'b0, push1};
    drops     = need - pushes;
    drop_sum  = {1'b0, drop_cnt} + (DROP_W+1)'(drops);

    out_kind = head.kind;
    out_idx  = head.idx;
    out_data = head.data;
    out_ts   = head.ts;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts       <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (drops != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      end
    end
  end

  trace_fifo_2w1r #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (push0),
    .push1 (push1),
    .din0  (rec0),
    .din1  (rec1),
    .pop   (pop),
    .head  (head),
    .level (level)
  );

endmodule

// File: tb/tb_riscv_trace_capture.sv
// Directed bench for riscv_trace_capture: vector table plus multi-cycle corner sequences.
module tb_riscv_trace_capture;
  import trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset, en, reg_write_sig, wr, rd, out_ready;
  logic [4:0]  reg_num;
  logic [31:0] reg_data, wr_data, rd_data;
  logic [8:0]  addr;
  logic        out_valid, overflow;
  kind_e       out_kind;
  logic [8:0]  out_idx;
  logic [31:0] out_data;
  logic [15:0] out_ts, drop_cnt, tb_ts;
  logic [4:0]  level;

  int passed = 0;
  int total  = 0;

  riscv_trace_capture #(.DEPTH(16), .TS_W(16), .DROP_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .reg_write_sig(reg_write_sig),
    .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_kind(out_kind), .out_idx(out_idx),
    .out_data(out_data), .out_ts(out_ts), .level(level),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Cycle counter since reset: the timestamp an event driven now will carry.
  always @(posedge clk) tb_ts <= reset ? 16'd0 : tb_ts + 16'd1;

  typedef struct {
    logic        en, rws;
    logic [4:0]  rn;
    logic [31:0] rdat;
    logic        w, r;
    logic [8:0]  a;
    logic [31:0] wd, rdd;
    int          n;
    kind_e       k0;
    logic [8:0]  i0;
    logic [31:0] d0;
    kind_e       k1;
    logic [8:0]  i1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic clear_in();
    en = 1'b1; reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
    wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
  endtask

  task automatic push_regs(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      reg_write_sig = 1'b1;
      reg_num = 5'((i % 31) + 1);
      reg_data = base + 32'(i);
      @(negedge clk);
    end
    clear_in();
  endtask

  task automatic chk_head(input string name, input kind_e k, input logic [8:0] i, input logic [31:0] d);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_kind"}, 64'(out_kind), 64'(k));
    chk({name, "_idx"}, 64'(out_idx), 64'(i));
    chk({name, "_data"}, 64'(out_data), 64'(d));
  endtask

  logic [15:0] exp_ts;
  logic [15:0] ts4[17];
  int          got;

  initial begin
    vecs[0] = '{1, 0, 5'd0, 32'h0, 1, 0, 9'd5, 32'hDEAD, 32'h0, 1,
                KIND_MEMW, 9'd5, 32'hDEAD, KIND_REG, 9'd0, 32'h0};
    vecs[1] = '{1, 1, 5'd10, 32'h7, 0, 1, 9'd3, 32'h0, 32'h7, 2,
                KIND_MEMR, 9'd3, 32'h7, KIND_REG, 9'd10, 32'h7};
    vecs[2] = '{1, 1, 5'd0, 32'h1234, 0, 0, 9'd0, 32'h0, 32'h0, 0,
                KIND_REG, 9'd0, 32'h0, KIND_REG, 9'd0, 32'h0};
    vecs[3] = '{1, 0, 5'd0, 32'h0, 1, 1, 9'd8, 32'h11, 32'h22, 0,
                KIND_REG, 9'd0, 32'h0, KIND_REG, 9'd0, 32'h0};
    vecs[4] = '{1, 1, 5'd31, 32'h12345678, 0, 0, 9'd0, 32'h0, 32'h0, 1,
                KIND_REG, 9'd31, 32'h12345678, KIND_REG, 9'd0, 32'h0};
    vecs[5] = '{0, 1, 5'd3, 32'h9, 1, 0, 9'd4, 32'h5, 32'h0, 0,
                KIND_REG, 9'd0, 32'h0, KIND_REG, 9'd0, 32'h0};
    vecs[6] = '{1, 1, 5'd4, 32'hCAFE, 1, 1, 9'd6, 32'h1, 32'h2, 1,
                KIND_REG, 9'd4, 32'hCAFE, KIND_REG, 9'd0, 32'h0};
    vecs[7] = '{1, 0, 5'd0, 32'h0, 0, 1, 9'h1FF, 32'h0, 32'hFFFFFFFF, 1,
                KIND_MEMR, 9'h1FF, 32'hFFFFFFFF, KIND_REG, 9'd0, 32'h0};

    clear_in();
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ts", 64'(out_ts), 64'd0);

    for (int v = 0; v < 8; v++) begin
      en = vecs[v].en; reg_write_sig = vecs[v].rws; reg_num = vecs[v].rn;
      reg_data = vecs[v].rdat; wr = vecs[v].w; rd = vecs[v].r; addr = vecs[v].a;
      wr_data = vecs[v].wd; rd_data = vecs[v].rdd;
      exp_ts = tb_ts;
      @(negedge clk);
      clear_in();
      got = 0;
      for (int k = 0; k < 4; k++) begin
        if (out_valid) begin
          if (got == 0)
            chk_head($sformatf("v%0d_r0", v), vecs[v].k0, vecs[v].i0, vecs[v].d0);
          else if (got == 1)
            chk_head($sformatf("v%0d_r1", v), vecs[v].k1, vecs[v].i1, vecs[v].d1);
          if (got < 2) chk($sformatf("v%0d_ts%0d", v, got), 64'(out_ts), 64'(exp_ts));
          got++;
        end
        @(negedge clk);
      end
      chk($sformatf("v%0d_count", v), 64'(got), 64'(vecs[v].n));
      chk($sformatf("v%0d_level", v), 64'(level), 64'd0);
      chk($sformatf("v%0d_drop", v), 64'(drop_cnt), 64'd0);
    end

    // Overfill: 17 writes into 16 slots with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr = 1'b1; addr = 9'(i); wr_data = 32'h100 + 32'(i);
      ts4[i] = tb_ts;
      @(negedge clk);
    end
    clear_in();
    chk("full_level", 64'(level), 64'd16);
    chk("full_drop", 64'(drop_cnt), 64'd1);
    chk("full_ovf", 64'(overflow), 64'd1);
    for (int c = 0; c < 5; c++) begin
      chk_head($sformatf("stall%0d", c), KIND_MEMW, 9'd0, 32'h100);
      chk($sformatf("stall%0d_ts", c), 64'(out_ts), 64'(ts4[0]));
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_head($sformatf("drain%0d", i), KIND_MEMW, 9'(i), 32'h100 + 32'(i));
      chk($sformatf("drain%0d_ts", i), 64'(out_ts), 64'(ts4[i]));
      @(negedge clk);
    end
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_ovf", 64'(overflow), 64'd1);
    chk("drain_drop", 64'(drop_cnt), 64'd1);

    // Load at 15 entries, stalled: MEM fits, REG is dropped.
    out_ready = 1'b0;
    push_regs(15, 32'hA000);
    chk("f15_level", 64'(level), 64'd15);
    rd = 1'b1; addr = 9'd7; rd_data = 32'h55;
    reg_write_sig = 1'b1; reg_num = 5'd9; reg_data = 32'h66;
    @(negedge clk);
    clear_in();
    chk("load_stall_level", 64'(level), 64'd16);
    chk("load_stall_drop", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk_head($sformatf("ls_drain%0d", i), KIND_REG, 9'((i % 31) + 1), 32'hA000 + 32'(i));
      @(negedge clk);
    end
    chk_head("ls_mem", KIND_MEMR, 9'd7, 32'h55);
    @(negedge clk);
    chk("ls_empty", 64'(out_valid), 64'd0);

    // Load at 15 entries with a same-cycle pop: both records fit.
    out_ready = 1'b0;
    push_regs(15, 32'hB000);
    rd = 1'b1; addr = 9'd12; rd_data = 32'h77;
    reg_write_sig = 1'b1; reg_num = 5'd9; reg_data = 32'h88;
    out_ready = 1'b1;
    @(negedge clk);
    clear_in();
    out_ready = 1'b0;
    chk("load_pop_level", 64'(level), 64'd16);
    chk("load_pop_drop", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    for (int i = 1; i < 15; i++) @(negedge clk);
    chk_head("lp_mem", KIND_MEMR, 9'd12, 32'h77);
    @(negedge clk);
    chk_head("lp_reg", KIND_REG, 9'd9, 32'h88);
    @(negedge clk);
    chk("lp_empty_level", 64'(level), 64'd0);

    // Reset in the middle of a stalled stream.
    out_ready = 1'b0;
    push_regs(3, 32'hC000);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_quiet%0d", c), 64'(out_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
